// File: rtl/loader_pkg.sv
// Shared definitions for the IMEM program loader: FSM states and frame constants.
package loader_pkg;

  // Width of one stream symbol.
  localparam int BYTE_W = 8;

  // Number of length bytes at the head of each frame.
  localparam int HDR_LEN = 2;

  // Loader FSM states. S_LEN_HI is the reset state.
  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus bundle: byte-stream handshake from the host link plus the
// IMEM write port.
// master = host/testbench side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_W = 11
);
  import loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs four big-endian stream bytes into one 32-bit word.
// word_valid_o fires combinationally on the edge-qualifying 4th byte. The word
// is presented alongside it, so the caller can register both in the same cycle.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_valid_o,
  output logic [31:0]       word_o
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
  assign word_o       = {shift_q, byte_i};

  // Count bytes within a word and shift earlier bytes toward the MSB end.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_valid_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {shift_q[15:0], byte_i};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the CPU instruction memory.
// Frame: LEN_HI, LEN_LO, 4*N big-endian data bytes, XOR checksum byte.
// The CPU is held in reset until a verified image is in IMEM.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  imem_loader_if.slave      bus,
  input  logic              reload,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  state_t              state_q;
  logic                in_ready_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [31:0]         imem_wdata_q;
  logic                cpu_rst_q;
  logic                done_q;
  logic                err_q;
  logic [ADDR_W:0]     words_q;
  logic [ADDR_W:0]     len_q;
  logic [BYTE_W-1:0]   len_hi_q;
  logic [BYTE_W-1:0]   xor_q;

  logic                accept_d;
  logic                data_accept_d;
  logic                clr_d;
  logic [15:0]         len_d;
  logic [ADDR_W:0]     words_inc_d;
  logic                word_valid_d;
  logic [31:0]         word_data_d;

  assign accept_d      = bus.in_valid && in_ready_q;
  assign data_accept_d = accept_d && (state_q == S_DATA);
  assign clr_d         = reload && ((state_q == S_DONE) || (state_q == S_ERROR));
  assign len_d         = {len_hi_q, bus.in_data};
  assign words_inc_d   = words_q + {{ADDR_W{1'b0}}, 1'b1};

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr_d),
    .byte_valid_i (data_accept_d),
    .byte_i       (bus.in_data),
    .word_valid_o (word_valid_d),
    .word_o       (word_data_d)
  );

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LEN_HI;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      words_q      <= '0;
      len_q        <= '0;
      len_hi_q     <= '0;
      xor_q        <= '0;
    end else begin
      imem_we_q <= 1'b0;
      // Release lags entry into S_DONE by one cycle; re-assert on reload immediately.
      cpu_rst_q <= !((state_q == S_DONE) && !reload);
      case (state_q)
        S_LEN_HI: begin
          if (accept_d) begin
            len_hi_q <= bus.in_data;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept_d) begin
            len_q <= len_d[ADDR_W:0];
            if (int'(len_d) > MAX_WORDS) begin
              state_q    <= S_ERROR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept_d) begin
            xor_q <= xor_q ^ bus.in_data;
            if (word_valid_d) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= words_q[ADDR_W-1:0];
              imem_wdata_q <= word_data_d;
              words_q      <= words_inc_d;
              if (words_inc_d == len_q) begin
                state_q <= S_CHECK;
              end
            end
          end
        end
        S_CHECK: begin
          if (accept_d) begin
            in_ready_q <= 1'b0;
            if (bus.in_data == xor_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (reload) begin
            state_q    <= S_LEN_HI;
            in_ready_q <= 1'b1;
            xor_q      <= '0;
            words_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_LEN_HI;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_rst        = cpu_rst_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_loaded   = words_q;

endmodule
